// File: rtl/rv_pkg.sv
// Shared definitions for the memory stage: result-source selects, load/store
// funct3 encodings, access size decode and the bus handshake state enum.
package rv_pkg;

    localparam logic [1:0] RES_ALU = 2'd0;
    localparam logic [1:0] RES_MEM = 2'd1;
    localparam logic [1:0] RES_PC4 = 2'd2;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } mem_size_t;

    // Any encoding not recognised for the access direction is a word access.
    function automatic mem_size_t mem_size(input logic [2:0] funct3, input logic is_store);
        mem_size_t sz;
        sz = SZ_WORD;
        if (is_store) begin
            case (funct3)
                F3_SB:   sz = SZ_BYTE;
                F3_SH:   sz = SZ_HALF;
                default: sz = SZ_WORD;
            endcase
        end else begin
            case (funct3)
                F3_LB, F3_LBU: sz = SZ_BYTE;
                F3_LH, F3_LHU: sz = SZ_HALF;
                default:       sz = SZ_WORD;
            endcase
        end
        return sz;
    endfunction

endpackage

// File: rtl/rv_load_align.sv
// Combinational load formatter: picks the byte/halfword lane from the read
// word by address offset and sign- or zero-extends according to funct3.
// Ports: i_rdata (bus word), i_addr (byte offset), i_funct3, o_data (result).
module rv_load_align
    import rv_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_addr,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_addr)
            2'd0: w_byte = i_rdata[7:0];
            2'd1: w_byte = i_rdata[15:8];
            2'd2: w_byte = i_rdata[23:16];
            2'd3: w_byte = i_rdata[31:24];
            default: w_byte = i_rdata[7:0];
        endcase
        w_half = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];

        o_data = i_rdata;
        case (i_funct3)
            F3_LB:   o_data = {{24{w_byte[7]}}, w_byte};
            F3_LBU:  o_data = {24'd0, w_byte};
            F3_LH:   o_data = {{16{w_half[15]}}, w_half};
            F3_LHU:  o_data = {16'd0, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/rv_memory.sv
// Memory stage: M-pipeline register, data bus request/handshake, store lane
// steering, load formatting, misalignment detection and forwarding value.
// Ports: i_clk/i_reset_n; execute-stage fields i_*; data bus o_dmem_*/i_dmem_*;
// o_stall holds upstream while a request waits for ack; o_misalign flags a
// suppressed access; o_rd_val forwards to execute; writeback fields o_*.
module rv_memory
    import rv_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic [31:0] i_alu_result,
    input  logic [31:0] i_rs2_val,
    input  logic [4:0]  i_rd,
    input  logic [31:2] i_pc_p4,
    input  logic [1:0]  i_res_src,
    input  logic [2:0]  i_funct3,
    input  logic        i_reg_write,
    input  logic        i_mem_read,
    input  logic        i_mem_write,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic [31:2] o_dmem_addr,
    output logic [3:0]  o_dmem_be,
    output logic [31:0] o_dmem_wdata,
    input  logic        i_dmem_ack,
    input  logic [31:0] i_dmem_rdata,
    output logic        o_stall,
    output logic        o_misalign,
    output logic [31:0] o_rd_val,
    output logic [31:0] o_load_data,
    output logic [31:0] o_alu_result,
    output logic        o_reg_write,
    output logic [4:0]  o_rd,
    output logic [31:2] o_pc_p4,
    output logic [1:0]  o_res_src
);

    logic [31:0] r_alu_result;
    logic [31:0] r_rs2_val;
    logic [4:0]  r_rd;
    logic [31:2] r_pc_p4;
    logic [1:0]  r_res_src;
    logic [2:0]  r_funct3;
    logic        r_reg_write;
    logic        r_mem_read;
    logic        r_mem_write;

    mem_state_t  r_state;
    mem_state_t  w_state_nxt;

    logic        w_mem_op;
    mem_size_t   w_size;
    logic        w_misalign;
    logic        w_req;
    logic [31:0] w_load_fmt;
    logic [3:0]  w_st_be;
    logic [31:0] w_st_wdata;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_alu_result <= '0;
            r_rs2_val    <= '0;
            r_rd         <= '0;
            r_pc_p4      <= '0;
            r_res_src    <= RES_ALU;
            r_funct3     <= '0;
            r_reg_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
        end else if (!o_stall) begin
            r_alu_result <= i_alu_result;
            r_rs2_val    <= i_rs2_val;
            r_rd         <= i_rd;
            r_pc_p4      <= i_pc_p4;
            r_res_src    <= i_res_src;
            r_funct3     <= i_funct3;
            r_reg_write  <= i_reg_write;
            r_mem_read   <= i_mem_read;
            r_mem_write  <= i_mem_write;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) r_state <= ST_IDLE;
        else            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_req && !i_dmem_ack) w_state_nxt = ST_WAIT;
            ST_WAIT: if (i_dmem_ack)           w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Request is derived purely from the held M-reg, so the bus fields stay
    // stable while stalled and drop asynchronously when reset clears M-reg.
    always_comb begin
        w_mem_op   = r_mem_read | r_mem_write;
        w_size     = mem_size(r_funct3, r_mem_write);
        w_misalign = w_mem_op &
                     (((w_size == SZ_HALF) && r_alu_result[0]) ||
                      ((w_size == SZ_WORD) && (r_alu_result[1:0] != 2'd0)));
        w_req      = w_mem_op & ~w_misalign;

        case (w_size)
            SZ_BYTE: begin
                w_st_be    = 4'b0001 << r_alu_result[1:0];
                w_st_wdata = {4{r_rs2_val[7:0]}};
            end
            SZ_HALF: begin
                w_st_be    = r_alu_result[1] ? 4'b1100 : 4'b0011;
                w_st_wdata = {2{r_rs2_val[15:0]}};
            end
            default: begin
                w_st_be    = 4'b1111;
                w_st_wdata = r_rs2_val;
            end
        endcase
    end

    rv_load_align u_load_align (
        .i_rdata  (i_dmem_rdata),
        .i_addr   (r_alu_result[1:0]),
        .i_funct3 (r_funct3),
        .o_data   (w_load_fmt)
    );

    always_comb begin
        o_dmem_req   = w_req;
        o_dmem_we    = w_req & r_mem_write;
        o_dmem_addr  = w_req ? r_alu_result[31:2] : '0;
        o_dmem_be    = !w_req ? 4'b0000 : (r_mem_write ? w_st_be : 4'b1111);
        o_dmem_wdata = (w_req && r_mem_write) ? w_st_wdata : '0;
        o_stall      = w_req & ~i_dmem_ack;
        o_misalign   = w_misalign;
        // Gated so a floating bus word never leaks out when no load is held.
        o_load_data  = r_mem_read ? w_load_fmt : '0;

        case (r_res_src)
            RES_MEM: o_rd_val = o_load_data;
            RES_PC4: o_rd_val = {r_pc_p4, 2'b00};
            default: o_rd_val = r_alu_result;
        endcase

        o_alu_result = r_alu_result;
        o_reg_write  = r_reg_write & ~w_misalign;
        o_rd         = r_rd;
        o_pc_p4      = r_pc_p4;
        o_res_src    = r_res_src;
    end

endmodule

// File: tb/tb_rv_memory.sv
module tb_rv_memory;
    import rv_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_reset_n;
    logic [31:0] i_alu_result, i_rs2_val, i_dmem_rdata;
    logic [4:0]  i_rd;
    logic [31:2] i_pc_p4;
    logic [1:0]  i_res_src;
    logic [2:0]  i_funct3;
    logic        i_reg_write, i_mem_read, i_mem_write, i_dmem_ack;
    logic        o_dmem_req, o_dmem_we, o_stall, o_misalign, o_reg_write;
    logic [31:2] o_dmem_addr, o_pc_p4;
    logic [3:0]  o_dmem_be;
    logic [31:0] o_dmem_wdata, o_rd_val, o_load_data, o_alu_result;
    logic [4:0]  o_rd;
    logic [1:0]  o_res_src;

    int n_checks = 0;
    int n_errors = 0;

    always #5 i_clk = ~i_clk;

    rv_memory dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n),
        .i_alu_result(i_alu_result), .i_rs2_val(i_rs2_val), .i_rd(i_rd),
        .i_pc_p4(i_pc_p4), .i_res_src(i_res_src), .i_funct3(i_funct3),
        .i_reg_write(i_reg_write), .i_mem_read(i_mem_read), .i_mem_write(i_mem_write),
        .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr),
        .o_dmem_be(o_dmem_be), .o_dmem_wdata(o_dmem_wdata),
        .i_dmem_ack(i_dmem_ack), .i_dmem_rdata(i_dmem_rdata),
        .o_stall(o_stall), .o_misalign(o_misalign), .o_rd_val(o_rd_val),
        .o_load_data(o_load_data), .o_alu_result(o_alu_result),
        .o_reg_write(o_reg_write), .o_rd(o_rd), .o_pc_p4(o_pc_p4), .o_res_src(o_res_src)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] rs2;
        logic [2:0]  f3;
        logic        rd_en;
        logic        wr_en;
        logic        regw;
        logic [1:0]  res;
        logic [4:0]  rd;
        logic [31:2] pc;
        logic [31:0] rdata;
        int          wait_cyc;
        logic        exp_req;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic        exp_mis;
        logic        exp_regw;
        logic [31:0] exp_load;
        logic [31:0] exp_rdval;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_nop();
        i_alu_result = '0; i_rs2_val = '0; i_rd = '0; i_pc_p4 = '0;
        i_res_src = RES_ALU; i_funct3 = '0;
        i_reg_write = 1'b0; i_mem_read = 1'b0; i_mem_write = 1'b0;
    endtask

    task automatic check_bus(input vec_t v, input string tag);
        check({tag, " req"},   {31'd0, o_dmem_req}, {31'd0, v.exp_req});
        if (v.exp_req) begin
            check({tag, " we"},    {31'd0, o_dmem_we}, {31'd0, v.wr_en});
            check({tag, " addr"},  {2'b00, o_dmem_addr}, {2'b00, v.addr[31:2]});
            check({tag, " be"},    {28'd0, o_dmem_be}, {28'd0, v.exp_be});
            if (v.wr_en) check({tag, " wdata"}, o_dmem_wdata, v.exp_wdata);
        end
    endtask

    task automatic apply(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("v%0d", idx);
        @(negedge i_clk);
        i_alu_result = v.addr; i_rs2_val = v.rs2; i_funct3 = v.f3;
        i_mem_read = v.rd_en; i_mem_write = v.wr_en; i_reg_write = v.regw;
        i_res_src = v.res; i_rd = v.rd; i_pc_p4 = v.pc;
        i_dmem_ack = 1'b0; i_dmem_rdata = '0;
        @(posedge i_clk); #1;
        check({tag, " misalign"}, {31'd0, o_misalign}, {31'd0, v.exp_mis});
        check({tag, " reg_write"}, {31'd0, o_reg_write}, {31'd0, v.exp_regw});
        check({tag, " rd"}, {27'd0, o_rd}, {27'd0, v.rd});
        check_bus(v, tag);
        if (v.exp_req) begin
            for (int n = 0; n < v.wait_cyc; n++) begin
                check({tag, " stall"}, {31'd0, o_stall}, 32'd1);
                @(posedge i_clk); #1;
                check_bus(v, {tag, " held"});
            end
            i_dmem_ack = 1'b1;
            i_dmem_rdata = v.rdata;
            #1;
            check({tag, " stall@ack"}, {31'd0, o_stall}, 32'd0);
        end
        check({tag, " load_data"}, o_load_data, v.exp_load);
        check({tag, " rd_val"}, o_rd_val, v.exp_rdval);
        drive_nop();
        @(posedge i_clk); #1;
        i_dmem_ack = 1'b0;
        i_dmem_rdata = '0;
        check({tag, " req after"}, {31'd0, o_dmem_req}, 32'd0);
        check({tag, " idle"}, {31'd0, dut.r_state == ST_IDLE}, 32'd1);
    endtask

    initial begin
        //        addr          rs2           f3    rd wr rw res      rd    pc            rdata         wt req be       wdata         mis rw load         rdval
        vecs[0]  = '{32'h100, 32'hDEADBEEF, F3_SW, 0, 1, 0, RES_ALU, 5'd0, 30'h0,       32'h0,        0, 1, 4'b1111, 32'hDEADBEEF, 0, 0, 32'h0,        32'h100};
        vecs[1]  = '{32'h103, 32'h000000A5, F3_SB, 0, 1, 0, RES_ALU, 5'd0, 30'h0,       32'h0,        1, 1, 4'b1000, 32'hA5A5A5A5, 0, 0, 32'h0,        32'h103};
        vecs[2]  = '{32'h102, 32'h1234BEEF, F3_SH, 0, 1, 0, RES_ALU, 5'd0, 30'h0,       32'h0,        0, 1, 4'b1100, 32'hBEEFBEEF, 0, 0, 32'h0,        32'h102};
        vecs[3]  = '{32'h102, 32'h0,        F3_LH, 1, 0, 1, RES_MEM, 5'd3, 30'h0,       32'h80010000, 3, 1, 4'b1111, 32'h0,        0, 1, 32'hFFFF8001, 32'hFFFF8001};
        vecs[4]  = '{32'h101, 32'h0,        F3_LBU,1, 0, 1, RES_MEM, 5'd4, 30'h0,       32'h0000F000, 0, 1, 4'b1111, 32'h0,        0, 1, 32'h000000F0, 32'h000000F0};
        vecs[5]  = '{32'h101, 32'h0,        F3_LB, 1, 0, 1, RES_MEM, 5'd5, 30'h0,       32'h0000F000, 0, 1, 4'b1111, 32'h0,        0, 1, 32'hFFFFFFF0, 32'hFFFFFFF0};
        vecs[6]  = '{32'h102, 32'h0,        F3_LHU,1, 0, 1, RES_MEM, 5'd6, 30'h0,       32'h80010000, 0, 1, 4'b1111, 32'h0,        0, 1, 32'h00008001, 32'h00008001};
        vecs[7]  = '{32'h104, 32'h0,        F3_LW, 1, 0, 1, RES_MEM, 5'd7, 30'h0,       32'h12345678, 2, 1, 4'b1111, 32'h0,        0, 1, 32'h12345678, 32'h12345678};
        vecs[8]  = '{32'h102, 32'h0,        F3_LW, 1, 0, 1, RES_MEM, 5'd8, 30'h0,       32'h0,        0, 0, 4'b0000, 32'h0,        1, 0, 32'h0,        32'h0};
        vecs[9]  = '{32'h101, 32'h5555,     F3_SH, 0, 1, 0, RES_ALU, 5'd0, 30'h0,       32'h0,        0, 0, 4'b0000, 32'h0,        1, 0, 32'h0,        32'h101};
        vecs[10] = '{32'hCAFE0000, 32'h0,   3'b000,0, 0, 1, RES_ALU, 5'd10,30'h0,       32'h0,        0, 0, 4'b0000, 32'h0,        0, 1, 32'h0,        32'hCAFE0000};
        vecs[11] = '{32'h0,     32'h0,      3'b000,0, 0, 1, RES_PC4, 5'd11,30'h400,     32'h0,        0, 0, 4'b0000, 32'h0,        0, 1, 32'h0,        32'h00001000};
        vecs[12] = '{32'h108, 32'h11223344, 3'b011,0, 1, 0, RES_ALU, 5'd0, 30'h0,       32'h0,        0, 1, 4'b1111, 32'h11223344, 0, 0, 32'h0,        32'h108};
        vecs[13] = '{32'h10A, 32'h0,        3'b110,1, 0, 1, RES_MEM, 5'd13,30'h0,       32'h0,        0, 0, 4'b0000, 32'h0,        1, 0, 32'h0,        32'h0};
        vecs[14] = '{32'h103, 32'h0,        F3_LB, 1, 0, 1, RES_MEM, 5'd14,30'h0,       32'h7F000000, 1, 1, 4'b1111, 32'h0,        0, 1, 32'h0000007F, 32'h0000007F};

        i_reset_n = 1'b0;
        i_dmem_ack = 1'b0;
        i_dmem_rdata = 32'hFFFFFFFF;
        drive_nop();
        @(posedge i_clk); @(posedge i_clk); #1;
        check("reset req", {31'd0, o_dmem_req}, 32'd0);
        check("reset load_data", o_load_data, 32'd0);
        check("reset rd_val", o_rd_val, 32'd0);
        check("reset stall", {31'd0, o_stall}, 32'd0);
        @(negedge i_clk);
        i_reset_n = 1'b1;
        i_dmem_rdata = '0;

        for (int k = 0; k < 15; k++) apply(k, vecs[k]);

        // Reset while a load is waiting, with the ack arriving late.
        @(negedge i_clk);
        i_alu_result = 32'h200; i_funct3 = F3_LW; i_mem_read = 1'b1;
        i_reg_write = 1'b1; i_rd = 5'd9; i_res_src = RES_MEM;
        @(posedge i_clk); #1;
        check("rst seq stall", {31'd0, o_stall}, 32'd1);
        @(posedge i_clk); #1;
        check("rst seq wait", {31'd0, dut.r_state == ST_WAIT}, 32'd1);
        #2;
        i_reset_n = 1'b0;
        i_dmem_ack = 1'b1;
        i_dmem_rdata = 32'hA5A5A5A5;
        #1;
        check("rst async req", {31'd0, o_dmem_req}, 32'd0);
        check("rst async stall", {31'd0, o_stall}, 32'd0);
        check("rst async reg_write", {31'd0, o_reg_write}, 32'd0);
        check("rst async rd", {27'd0, o_rd}, 32'd0);
        check("rst async alu", o_alu_result, 32'd0);
        check("rst async load", o_load_data, 32'd0);
        check("rst async be", {28'd0, o_dmem_be}, 32'd0);
        check("rst async idle", {31'd0, dut.r_state == ST_IDLE}, 32'd1);
        drive_nop();
        @(posedge i_clk); #1;
        check("rst held req", {31'd0, o_dmem_req}, 32'd0);
        @(negedge i_clk);
        i_reset_n = 1'b1;
        @(posedge i_clk); #1;
        check("late ack req", {31'd0, o_dmem_req}, 32'd0);
        check("late ack reg_write", {31'd0, o_reg_write}, 32'd0);
        check("late ack idle", {31'd0, dut.r_state == ST_IDLE}, 32'd1);
        i_dmem_ack = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
